// File: rtl/ctrl_alu_unit_pkg.sv
// Shared encodings for the control decoder and ALU: opcodes, funct codes,
// ALU operation classes and ALU control codes.
package ctrl_alu_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BR     = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_BR_ALT = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100,
        ALU_NOP = 4'b1111
    } alu_ctr_e;

    // Unknown funct codes map to a no-op code whose ALU result is zero.
    function automatic alu_ctr_e decode_funct(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_alu_exec.sv
// Combinational ALU datapath: result selection by ALU control code and zero flag.
module ctrl_alu_exec
    import ctrl_alu_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_ctr,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_res,
    output logic             o_zero
);

    logic [WIDTH-1:0] w_res;

    always_comb begin
        w_res = '0;
        case (i_ctr)
            ALU_AND: w_res = i_a & i_b;
            ALU_OR:  w_res = i_a | i_b;
            ALU_ADD: w_res = i_a + i_b;
            ALU_SUB: w_res = i_a - i_b;
            ALU_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_NOR: w_res = ~(i_a | i_b);
            default: w_res = '0;
        endcase
    end

    assign o_res  = w_res;
    assign o_zero = (w_res == '0);

endmodule

// File: rtl/ctrl_alu_unit.sv
// Single-cycle control unit: main decoder, ALU control decoder, ALU instance
// and one-cycle registered copies of the ALU result and zero flag.
module ctrl_alu_unit
    import ctrl_alu_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic [5:0]       opCode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             regDst,
    output logic             jump,
    output logic             branch,
    output logic             memRead,
    output logic             memToReg,
    output logic             memWrite,
    output logic             aluSrc,
    output logic             regWrite,
    output logic [1:0]       aluOp,
    output logic [3:0]       aluCtr,
    output logic [WIDTH-1:0] aluRes,
    output logic             zero,
    output logic [WIDTH-1:0] resQ,
    output logic             zeroQ
);

    alu_op_e          w_alu_op;
    alu_ctr_e         w_alu_ctr;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_zero;
    logic [WIDTH-1:0] r_res;
    logic             r_zero;

    // Reset gates the decoder combinationally so controls drop without a clock.
    always_comb begin
        regDst   = 1'b0;
        aluSrc   = 1'b0;
        memToReg = 1'b0;
        regWrite = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        w_alu_op = ALUOP_MEM;
        if (!reset) begin
            case (opCode)
                OP_RTYPE: begin
                    regDst   = 1'b1;
                    regWrite = 1'b1;
                    w_alu_op = ALUOP_RTYPE;
                end
                OP_LW: begin
                    aluSrc   = 1'b1;
                    memToReg = 1'b1;
                    regWrite = 1'b1;
                    memRead  = 1'b1;
                end
                OP_SW: begin
                    aluSrc   = 1'b1;
                    memWrite = 1'b1;
                end
                OP_BEQ: begin
                    branch   = 1'b1;
                    w_alu_op = ALUOP_BR;
                end
                OP_J: begin
                    jump     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_alu_ctr = ALU_ADD;
        if (w_alu_op[0])
            w_alu_ctr = ALU_SUB;
        else if (w_alu_op == ALUOP_RTYPE)
            w_alu_ctr = decode_funct(funct);
    end

    ctrl_alu_exec #(
        .WIDTH (WIDTH)
    ) u_exec (
        .i_ctr  (w_alu_ctr),
        .i_a    (input1),
        .i_b    (input2),
        .o_res  (w_alu_res),
        .o_zero (w_zero)
    );

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_res  <= '0;
            r_zero <= 1'b0;
        end else begin
            r_res  <= w_alu_res;
            r_zero <= w_zero;
        end
    end

    assign aluOp  = w_alu_op;
    assign aluCtr = w_alu_ctr;
    assign aluRes = w_alu_res;
    assign zero   = w_zero;
    assign resQ   = r_res;
    assign zeroQ  = r_zero;

endmodule

// File: tb/tb_ctrl_alu_unit.sv
// Directed self-checking bench for ctrl_alu_unit.
module tb_ctrl_alu_unit;

    logic        clock_in = 1'b0;
    logic        reset;
    logic [5:0]  opCode;
    logic [5:0]  funct;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        regDst, jump, branch, memRead, memToReg, memWrite, aluSrc, regWrite;
    logic [1:0]  aluOp;
    logic [3:0]  aluCtr;
    logic [31:0] aluRes;
    logic        zero;
    logic [31:0] resQ;
    logic        zeroQ;
    logic [9:0]  ctl;

    int checks   = 0;
    int failures = 0;

    always #5 clock_in = ~clock_in;

    ctrl_alu_unit #(.WIDTH(32)) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .opCode   (opCode),
        .funct    (funct),
        .input1   (input1),
        .input2   (input2),
        .regDst   (regDst),
        .jump     (jump),
        .branch   (branch),
        .memRead  (memRead),
        .memToReg (memToReg),
        .memWrite (memWrite),
        .aluSrc   (aluSrc),
        .regWrite (regWrite),
        .aluOp    (aluOp),
        .aluCtr   (aluCtr),
        .aluRes   (aluRes),
        .zero     (zero),
        .resQ     (resQ),
        .zeroQ    (zeroQ)
    );

    // regDst,aluSrc,memToReg,regWrite,memRead,memWrite,branch,jump,aluOp
    assign ctl = {regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch, jump, aluOp};

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clock_in);
        opCode = op;
        funct  = fn;
        input1 = a;
        input2 = b;
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        opCode = 6'b000000;
        funct  = 6'b100010;
        input1 = 32'd3;
        input2 = 32'd5;
        #2;
        checks++;
        if (ctl !== 10'b0) begin
            failures++;
            $display("FAIL reset_ctl actual=%b required=%b", ctl, 10'b0);
        end
        checks++;
        if (aluCtr !== 4'b0010) begin
            failures++;
            $display("FAIL reset_aluctr actual=%b required=%b", aluCtr, 4'b0010);
        end
        checks++;
        if (aluRes !== 32'd8 || zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_alures actual=%h/%b required=%h/0", aluRes, zero, 32'd8);
        end
        checks++;
        if (resQ !== 32'd0 || zeroQ !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs actual=%h/%b required=0/0", resQ, zeroQ);
        end
        @(negedge clock_in);
        reset = 1'b0;
    endtask

    task automatic test_lw_sw();
        drive(6'b100011, 6'b000000, 32'd8, 32'd4);
        checks++;
        if (ctl !== 10'b0111100000) begin
            failures++;
            $display("FAIL lw_ctl actual=%b required=%b", ctl, 10'b0111100000);
        end
        checks++;
        if (aluCtr !== 4'b0010 || aluRes !== 32'd12 || zero !== 1'b0) begin
            failures++;
            $display("FAIL lw_alu actual=%b/%h/%b required=0010/0000000c/0", aluCtr, aluRes, zero);
        end
        drive(6'b101011, 6'b000000, 32'd100, 32'hFFFF_FFFC);
        checks++;
        if (ctl !== 10'b0100010000 || aluRes !== 32'd96) begin
            failures++;
            $display("FAIL sw actual=%b/%h required=0100010000/00000060", ctl, aluRes);
        end
    endtask

    task automatic test_beq();
        drive(6'b000100, 6'b101010, 32'd5, 32'd5);
        checks++;
        if (ctl !== 10'b0000001001 || aluCtr !== 4'b0110) begin
            failures++;
            $display("FAIL beq_ctl actual=%b/%b required=0000001001/0110", ctl, aluCtr);
        end
        checks++;
        if (aluRes !== 32'd0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL beq_eq actual=%h/%b required=0/1", aluRes, zero);
        end
        drive(6'b000100, 6'b000000, 32'd5, 32'd6);
        checks++;
        if (aluRes !== 32'hFFFF_FFFF || zero !== 1'b0) begin
            failures++;
            $display("FAIL beq_ne actual=%h/%b required=ffffffff/0", aluRes, zero);
        end
    endtask

    task automatic test_rtype();
        drive(6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1);
        checks++;
        if (ctl !== 10'b1001000010 || aluCtr !== 4'b0111) begin
            failures++;
            $display("FAIL rtype_ctl actual=%b/%b required=1001000010/0111", ctl, aluCtr);
        end
        checks++;
        if (aluRes !== 32'd1 || zero !== 1'b0) begin
            failures++;
            $display("FAIL slt_neg actual=%h/%b required=1/0", aluRes, zero);
        end
        drive(6'b000000, 6'b101010, 32'd1, 32'hFFFF_FFFF);
        checks++;
        if (aluRes !== 32'd0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL slt_pos actual=%h/%b required=0/1", aluRes, zero);
        end
        drive(6'b000000, 6'b100100, 32'h0000_F0F0, 32'h00FF_00FF);
        checks++;
        if (aluCtr !== 4'b0000 || aluRes !== 32'h0000_00F0) begin
            failures++;
            $display("FAIL and actual=%b/%h required=0000/000000f0", aluCtr, aluRes);
        end
        drive(6'b000000, 6'b100101, 32'h0000_F0F0, 32'h00FF_00FF);
        checks++;
        if (aluCtr !== 4'b0001 || aluRes !== 32'h00FF_F0FF) begin
            failures++;
            $display("FAIL or actual=%b/%h required=0001/00fff0ff", aluCtr, aluRes);
        end
        drive(6'b000000, 6'b100000, 32'h7FFF_FFFF, 32'd1);
        checks++;
        if (aluCtr !== 4'b0010 || aluRes !== 32'h8000_0000) begin
            failures++;
            $display("FAIL add_wrap actual=%b/%h required=0010/80000000", aluCtr, aluRes);
        end
        drive(6'b000000, 6'b100010, 32'd0, 32'd1);
        checks++;
        if (aluCtr !== 4'b0110 || aluRes !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL sub_wrap actual=%b/%h required=0110/ffffffff", aluCtr, aluRes);
        end
        drive(6'b000000, 6'b000000, 32'd7, 32'd9);
        checks++;
        if (aluCtr !== 4'b1111 || aluRes !== 32'd0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL nop_word0 actual=%b/%h/%b required=1111/0/1", aluCtr, aluRes, zero);
        end
        drive(6'b000000, 6'b000111, 32'd7, 32'd9);
        checks++;
        if (aluCtr !== 4'b1111 || aluRes !== 32'd0) begin
            failures++;
            $display("FAIL nop_funct actual=%b/%h required=1111/0", aluCtr, aluRes);
        end
    endtask

    task automatic test_jump_other();
        drive(6'b000010, 6'b100010, 32'd1, 32'd2);
        checks++;
        if (ctl !== 10'b0000000100 || jump !== 1'b1 || regWrite !== 1'b0) begin
            failures++;
            $display("FAIL jump actual=%b required=0000000100", ctl);
        end
        drive(6'b111111, 6'b100010, 32'd1, 32'd2);
        checks++;
        if (ctl !== 10'b0 || aluCtr !== 4'b0010 || aluRes !== 32'd3) begin
            failures++;
            $display("FAIL other_op actual=%b/%b/%h required=0/0010/3", ctl, aluCtr, aluRes);
        end
    endtask

    task automatic test_registered();
        drive(6'b100011, 6'b000000, 32'd8, 32'd4);
        @(posedge clock_in);
        #1;
        checks++;
        if (resQ !== 32'd12 || zeroQ !== 1'b0) begin
            failures++;
            $display("FAIL capture actual=%h/%b required=0000000c/0", resQ, zeroQ);
        end
        // inputs change before the edge: registered copy still holds the old value
        drive(6'b000100, 6'b000000, 32'd5, 32'd5);
        checks++;
        if (resQ !== 32'd12 || zeroQ !== 1'b0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL latency actual=%h/%b/%b required=0000000c/0/1", resQ, zeroQ, zero);
        end
        @(posedge clock_in);
        #1;
        checks++;
        if (resQ !== 32'd0 || zeroQ !== 1'b1) begin
            failures++;
            $display("FAIL capture_zero actual=%h/%b required=0/1", resQ, zeroQ);
        end
        drive(6'b100011, 6'b000000, 32'd8, 32'd4);
        @(posedge clock_in);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (resQ !== 32'd0 || zeroQ !== 1'b0 || ctl !== 10'b0) begin
            failures++;
            $display("FAIL midcycle_reset actual=%h/%b/%b required=0/0/0", resQ, zeroQ, ctl);
        end
        @(posedge clock_in);
        #1;
        checks++;
        if (resQ !== 32'd0 || aluRes !== 32'd12) begin
            failures++;
            $display("FAIL held_reset actual=%h/%h required=0/0000000c", resQ, aluRes);
        end
        @(negedge clock_in);
        reset = 1'b0;
        #1;
        checks++;
        if (resQ !== 32'd0 || memRead !== 1'b1) begin
            failures++;
            $display("FAIL release actual=%h/%b required=0/1", resQ, memRead);
        end
        @(posedge clock_in);
        #1;
        checks++;
        if (resQ !== 32'd12 || zeroQ !== 1'b0) begin
            failures++;
            $display("FAIL recapture actual=%h/%b required=0000000c/0", resQ, zeroQ);
        end
    endtask

    initial begin
        test_reset();
        test_lw_sw();
        test_beq();
        test_rtype();
        test_jump_other();
        test_registered();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
